vga_timing_gen: RTL and testbench

//  Raster timing generator for the 640x480@60 display path. Runs on the 25 MHz

---
 rtl/vga_timing_gen_if.sv | 24 ++
 rtl/vga_timing_gen.sv | 83 ++++++++
 tb/tb_vga_timing_gen.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_timing_gen_if                                                        |
// | Raster timing bundle: syncs, visible flag, pixel coordinates, markers.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface vga_timing_gen_if;
    logic       hs;
    logic       vs;
    logic       blank;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       frame_start;
    logic       line_end;

    modport master (
        output hs, vs, blank, DrawX, DrawY, frame_start, line_end
    );

    modport slave (
        input  hs, vs, blank, DrawX, DrawY, frame_start, line_end
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_timing_gen                                                           |
// | 640x480@60 raster counters with zero-skew registered sync/blank decode.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vga_timing_gen #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  wire logic           vga_clk,
    input  wire logic           reset,
    vga_timing_gen_if.master    o_vga
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] c_H_LAST     = 10'(H_TOT - 1);
    localparam logic [9:0] c_V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0] c_H_VIS      = 10'(H_VIS);
    localparam logic [9:0] c_V_VIS      = 10'(V_VIS);
    localparam logic [9:0] c_HS_START   = 10'(H_VIS + H_FP);
    localparam logic [9:0] c_HS_END     = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] c_VS_START   = 10'(V_VIS + V_FP);
    localparam logic [9:0] c_VS_END     = 10'(V_VIS + V_FP + V_SYNC);

    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank;
    logic       r_frame_start;
    logic       r_line_end;

    logic       w_h_last;
    logic       w_v_last;
    logic [9:0] w_hc_nxt;
    logic [9:0] w_vc_nxt;

    assign w_h_last = (r_hc == c_H_LAST);
    assign w_v_last = (r_vc == c_V_LAST);
    assign w_hc_nxt = w_h_last ? 10'd0 : (r_hc + 10'd1);
    assign w_vc_nxt = !w_h_last ? r_vc : (w_v_last ? 10'd0 : (r_vc + 10'd1));

    // Flags decode the next-state position so they land on the same edge as
    // the coordinates they describe.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_hc          <= 10'd0;
            r_vc          <= 10'd0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_end    <= 1'b0;
        end else begin
            r_hc          <= w_hc_nxt;
            r_vc          <= w_vc_nxt;
            r_hs          <= !((w_hc_nxt >= c_HS_START) && (w_hc_nxt < c_HS_END));
            r_vs          <= !((w_vc_nxt >= c_VS_START) && (w_vc_nxt < c_VS_END));
            r_blank       <= (w_hc_nxt < c_H_VIS) && (w_vc_nxt < c_V_VIS);
            r_frame_start <= (w_hc_nxt == 10'd0) && (w_vc_nxt == 10'd0);
            r_line_end    <= (w_hc_nxt == c_H_LAST);
        end
    end

    assign o_vga.hs          = r_hs;
    assign o_vga.vs          = r_vs;
    assign o_vga.blank       = r_blank;
    assign o_vga.DrawX       = r_hc;
    assign o_vga.DrawY       = r_vc;
    assign o_vga.frame_start = r_frame_start;
    assign o_vga.line_end    = r_line_end;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_timing_gen                                                        |
// | Directed checks on full 640x480 timing plus a shrunken-frame instance.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vga_timing_gen;

    logic clk;
    logic rst;
    logic r_sb_en;
    int   n_vec;
    int   n_err;

    vga_timing_gen_if if_big ();
    vga_timing_gen_if if_small ();

    vga_timing_gen u_big (
        .vga_clk (clk),
        .reset   (rst),
        .o_vga   (if_big)
    );

    // Shrunken frame: 25 x 15, hsync x=18..21, vsync y=10..11, visible 16x8.
    vga_timing_gen #(
        .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VIS(8),  .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_small (
        .vga_clk (clk),
        .reset   (rst),
        .o_vga   (if_small)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference position, independent of the DUT: position is the pixel being shown.
    int mbx = 0, mby = 0, msx = 0, msy = 0;
    bit mfresh = 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mbx <= 0; mby <= 0; msx <= 0; msy <= 0; mfresh <= 1'b1;
        end else begin
            mfresh <= 1'b0;
            mbx <= (mbx == 799) ? 0 : mbx + 1;
            mby <= (mbx == 799) ? ((mby == 524) ? 0 : mby + 1) : mby;
            msx <= (msx == 24) ? 0 : msx + 1;
            msy <= (msx == 24) ? ((msy == 14) ? 0 : msy + 1) : msy;
        end
    end

    // {hs, vs, blank, frame_start, line_end}
    function automatic logic [4:0] exp_flags(input int x, input int y,
                                             input int hv, input int hf, input int hsy, input int ht,
                                             input int vv, input int vf, input int vsy, input bit fresh);
        logic [4:0] f;
        if (fresh) return 5'b11000;
        f[4] = (x < hv + hf) || (x >= hv + hf + hsy);
        f[3] = (y < vv + vf) || (y >= vv + vf + vsy);
        f[2] = (x < hv) && (y < vv);
        f[1] = (x == 0) && (y == 0);
        f[0] = (x == ht - 1);
        return f;
    endfunction

    always @(negedge clk) begin
        if (r_sb_en) begin
            check("sb_big_x", if_big.DrawX, mbx);
            check("sb_big_y", if_big.DrawY, mby);
            check("sb_big_flags",
                  {if_big.hs, if_big.vs, if_big.blank, if_big.frame_start, if_big.line_end},
                  exp_flags(mbx, mby, 640, 16, 96, 800, 480, 10, 2, mfresh));
            check("sb_small_x", if_small.DrawX, msx);
            check("sb_small_y", if_small.DrawY, msy);
            check("sb_small_flags",
                  {if_small.hs, if_small.vs, if_small.blank, if_small.frame_start, if_small.line_end},
                  exp_flags(msx, msy, 16, 2, 4, 25, 8, 2, 2, mfresh));
        end
    end

    task automatic chk_reset_vals(input string tag);
        check({tag, "_x"},  if_big.DrawX, 0);
        check({tag, "_y"},  if_big.DrawY, 0);
        check({tag, "_hs"}, if_big.hs, 1);
        check({tag, "_vs"}, if_big.vs, 1);
        check({tag, "_blank"}, if_big.blank, 0);
        check({tag, "_fs"}, if_big.frame_start, 0);
        check({tag, "_le"}, if_big.line_end, 0);
        check({tag, "_small_hs"}, if_small.hs, 1);
        check({tag, "_small_blank"}, if_small.blank, 0);
    endtask

    initial begin
        int n;
        int hs_low, hs_first, blank_cnt, blank_last, le_cnt, le_x;
        int vs_low, vs_first, blank_late, fs_cnt, vs_odd;
        logic prev_vs;
        logic [9:0] prev_y;

        n_vec   = 0;
        n_err   = 0;
        r_sb_en = 1'b0;
        rst     = 1'b1;

        repeat (5) begin
            @(negedge clk);
            chk_reset_vals("rst_hold");
        end
        r_sb_en = 1'b1;
        #2 rst = 1'b0;

        @(negedge clk);
        check("rel_big_x", if_big.DrawX, 1);
        check("rel_big_y", if_big.DrawY, 0);
        check("rel_big_blank", if_big.blank, 1);
        check("rel_big_fs", if_big.frame_start, 0);
        check("rel_small_x", if_small.DrawX, 1);

        // One full line of the 640x480 instance.
        n = 0;
        while (if_big.DrawX != 10'd0 && n < 900) begin @(negedge clk); n++; end
        check("wait_line_start", if_big.DrawX, 0);
        hs_low = 0; hs_first = -1; blank_cnt = 0; blank_last = -1; le_cnt = 0; le_x = -1;
        for (int i = 0; i < 800; i++) begin
            if (!if_big.hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(if_big.DrawX);
            end
            if (if_big.blank) begin
                blank_cnt++;
                blank_last = int'(if_big.DrawX);
            end
            if (if_big.line_end) begin
                le_cnt++;
                le_x = int'(if_big.DrawX);
            end
            @(negedge clk);
        end
        check("hs_low_cycles", hs_low, 96);
        check("hs_first_x", hs_first, 656);
        check("blank_cycles", blank_cnt, 640);
        check("blank_last_x", blank_last, 639);
        check("line_end_cnt", le_cnt, 1);
        check("line_end_x", le_x, 799);

        // One full frame of the shrunken instance.
        n = 0;
        while (!if_small.frame_start && n < 400) begin @(negedge clk); n++; end
        check("wait_frame_start", if_small.frame_start, 1);
        vs_low = 0; vs_first = -1; blank_late = 0; fs_cnt = 0; vs_odd = 0;
        prev_vs = if_small.vs; prev_y = if_small.DrawY;
        for (int i = 0; i < 375; i++) begin
            if (!if_small.vs) begin
                vs_low++;
                if (vs_first < 0) vs_first = int'(if_small.DrawY);
            end
            if (if_small.blank && if_small.DrawY >= 10'd8) blank_late++;
            if (if_small.frame_start) fs_cnt++;
            if (if_small.vs != prev_vs && if_small.DrawY == prev_y) vs_odd++;
            prev_vs = if_small.vs;
            prev_y  = if_small.DrawY;
            @(negedge clk);
        end
        check("vs_low_cycles", vs_low, 50);
        check("vs_first_y", vs_first, 10);
        check("blank_below_vis", blank_late, 0);
        check("fs_per_frame", fs_cnt, 1);
        check("fs_period", if_small.frame_start, 1);
        check("vs_without_y", vs_odd, 0);

        // Frame wrap on the shrunken instance.
        n = 0;
        while (!(if_small.DrawX == 10'd24 && if_small.DrawY == 10'd14) && n < 400) begin
            @(negedge clk); n++;
        end
        check("wrap_reach_x", if_small.DrawX, 24);
        check("wrap_le", if_small.line_end, 1);
        @(negedge clk);
        check("wrap_x", if_small.DrawX, 0);
        check("wrap_y", if_small.DrawY, 0);
        check("wrap_fs", if_small.frame_start, 1);
        @(negedge clk);
        check("wrap_fs_drop", if_small.frame_start, 0);
        check("wrap_x1", if_small.DrawX, 1);

        // Three shrunken frames under the per-cycle model.
        repeat (1125) @(negedge clk);

        // Async reset in the middle of hsync.
        n = 0;
        while (if_big.DrawX != 10'd700 && n < 900) begin @(negedge clk); n++; end
        check("wait_x700", if_big.DrawX, 700);
        check("pre_rst_hs", if_big.hs, 0);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rerel_big_x", if_big.DrawX, 1);
        check("rerel_big_y", if_big.DrawY, 0);
        check("rerel_small_x", if_small.DrawX, 1);
        repeat (50) @(negedge clk);
        r_sb_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
